// File: rtl/gelu_row_streamer_if.sv
// rtl/gelu_row_streamer_if.sv - row stream bundle (active-low valid, active-high ready)
interface gelu_row_streamer_if #(
    parameter int ROW_WIDTH = 512,
    parameter int IDX_WIDTH = 7
);
    logic [ROW_WIDTH-1:0] row_data;
    logic [IDX_WIDTH-1:0] row_idx;
    logic                 row_valid_n;
    logic                 row_ready;

    modport master (
        output row_data,
        output row_idx,
        output row_valid_n,
        input  row_ready
    );

    modport slave (
        input  row_data,
        input  row_idx,
        input  row_valid_n,
        output row_ready
    );
endinterface

// File: rtl/gelu_row_streamer.sv
// rtl/gelu_row_streamer.sv - captures a GELU tensor and replays it one row per transfer
// Optional: GELU_STREAM_DROP_CNT_EN adds a saturating count of ignored captures (drop_cnt).
module gelu_row_streamer #(
    parameter  int GELU_NUM     = 128,
    parameter  int DIMENTION    = 64,
    parameter  int OUTPUT_WIDTH = 8,
    localparam int ROW_WIDTH    = OUTPUT_WIDTH * DIMENTION,
    localparam int IDX_WIDTH    = (GELU_NUM > 1) ? $clog2(GELU_NUM) : 1,
    localparam int TENSOR_WIDTH = ROW_WIDTH * GELU_NUM
) (
    input  logic                    clk_p,
    input  logic                    rst_n,
    input  logic [TENSOR_WIDTH-1:0] gelu,
    input  logic                    gelu_valid_n,
    output logic                    accept_n,
    gelu_row_streamer_if.master     rs,
    output logic                    frame_done_n
`ifdef GELU_STREAM_DROP_CNT_EN
    ,
    output logic [15:0]             drop_cnt
`endif
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(GELU_NUM - 1);

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    frame_done_n_q, frame_done_n_d;
    logic [TENSOR_WIDTH-1:0] tensor_q, tensor_d;

    logic xfer;
    logic last_xfer;
    logic capture;

    // accept_n opens combinationally on the last-row transfer so a new frame can follow with no bubble
    always_comb begin
        xfer      = (state_q == ST_STREAM) && rs.row_ready;
        last_xfer = xfer && (cnt_q == LAST_IDX);
        accept_n  = !((state_q == ST_IDLE) || last_xfer);
        capture   = !accept_n && !gelu_valid_n;
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        frame_done_n_d = !last_xfer;
        tensor_d       = capture ? gelu : tensor_q;
        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    state_d = ST_STREAM;
                    cnt_d   = '0;
                end
            end
            ST_STREAM: begin
                if (last_xfer) begin
                    cnt_d   = '0;
                    state_d = capture ? ST_STREAM : ST_IDLE;
                end else if (xfer) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            frame_done_n_q <= 1'b1;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            frame_done_n_q <= frame_done_n_d;
        end
    end

    // Capture buffer needs no reset: it is only read while streaming, after a capture has filled it
    always_ff @(posedge clk_p) begin
        tensor_q <= tensor_d;
    end

    assign rs.row_valid_n = (state_q != ST_STREAM);
    assign rs.row_idx     = cnt_q;
    assign rs.row_data    = (state_q == ST_STREAM) ? tensor_q[cnt_q * ROW_WIDTH +: ROW_WIDTH] : '0;
    assign frame_done_n   = frame_done_n_q;

`ifdef GELU_STREAM_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (!gelu_valid_n && accept_n && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_gelu_row_streamer.sv
// tb/tb_gelu_row_streamer.sv - directed self-checking bench for gelu_row_streamer
module tb_gelu_row_streamer;
    localparam int GN = 4;
    localparam int DIM = 2;
    localparam int OW = 8;
    localparam int RW = OW * DIM;
    localparam int IW = 2;

    logic              clk_p = 1'b0;
    logic              rst_n;
    logic [RW*GN-1:0]  gelu;
    logic              gelu_valid_n;
    logic              accept_n;
    logic              frame_done_n;
`ifdef GELU_STREAM_DROP_CNT_EN
    logic [15:0]       drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    gelu_row_streamer_if #(.ROW_WIDTH(RW), .IDX_WIDTH(IW)) rs_if ();

    gelu_row_streamer #(
        .GELU_NUM    (GN),
        .DIMENTION   (DIM),
        .OUTPUT_WIDTH(OW)
    ) dut (
        .clk_p       (clk_p),
        .rst_n       (rst_n),
        .gelu        (gelu),
        .gelu_valid_n(gelu_valid_n),
        .accept_n    (accept_n),
        .rs          (rs_if.master),
        .frame_done_n(frame_done_n)
`ifdef GELU_STREAM_DROP_CNT_EN
        ,
        .drop_cnt    (drop_cnt)
`endif
    );

    always #5 clk_p = ~clk_p;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Row i of a frame with base b holds elements {b+i, -(b+i)}
    function automatic logic [RW-1:0] exp_row(input logic [7:0] base, input int i);
        logic [7:0] e;
        e = base + 8'(i);
        return {e, 8'(-e)};
    endfunction

    function automatic logic [RW*GN-1:0] make_frame(input logic [7:0] base);
        logic [RW*GN-1:0] f;
        for (int i = 0; i < GN; i++) f[i*RW +: RW] = exp_row(base, i);
        return f;
    endfunction

    task automatic check_row(input string tag, input logic [7:0] base, input int i);
        check({tag, "_valid"}, 64'(rs_if.row_valid_n), 64'(0));
        check({tag, "_idx"}, 64'(rs_if.row_idx), 64'(i));
        check({tag, "_data"}, 64'(rs_if.row_data), 64'(exp_row(base, i)));
    endtask

    // Presents a tensor for one edge, starting at the current negedge
    task automatic offer(input logic [7:0] base);
        gelu = make_frame(base);
        gelu_valid_n = 1'b0;
    endtask

    task automatic check_done_pulse(input string tag);
        check({tag, "_done_lo"}, 64'(frame_done_n), 64'(0));
        check({tag, "_idle_valid"}, 64'(rs_if.row_valid_n), 64'(1));
        check({tag, "_accept"}, 64'(accept_n), 64'(0));
        @(negedge clk_p);
        check({tag, "_done_hi"}, 64'(frame_done_n), 64'(1));
    endtask

    int exp_i;
    int cyc;
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        rst_n = 1'b0;
        gelu = '0;
        gelu_valid_n = 1'b1;
        rs_if.row_ready = 1'b1;
        repeat (2) @(negedge clk_p);
        check("rst_valid", 64'(rs_if.row_valid_n), 64'(1));
        check("rst_done", 64'(frame_done_n), 64'(1));
        check("rst_accept", 64'(accept_n), 64'(0));
        check("rst_idx", 64'(rs_if.row_idx), 64'(0));
        check("rst_data", 64'(rs_if.row_data), 64'(0));
`ifdef GELU_STREAM_DROP_CNT_EN
        check("rst_drop", 64'(drop_cnt), 64'(0));
`endif
        rst_n = 1'b1;

        // Single frame, ready held high
        @(negedge clk_p);
        offer(8'h00);
        for (int i = 0; i < GN; i++) begin
            @(negedge clk_p);
            gelu_valid_n = 1'b1;
            check_row("single", 8'h00, i);
            check("single_accept", 64'(accept_n), 64'(i == GN - 1 ? 0 : 1));
            check("single_done_hi", 64'(frame_done_n), 64'(1));
        end
        @(negedge clk_p);
        check_done_pulse("single");

        // Backpressure: ready pattern 1,0,0,1 repeating
        offer(8'h10);
        @(negedge clk_p);
        gelu_valid_n = 1'b1;
        exp_i = 0;
        cyc = 0;
        while (exp_i < GN && cyc < 40) begin
            rs_if.row_ready = pat[cyc % 4];
            check_row("bp", 8'h10, exp_i);
            if (rs_if.row_ready) exp_i++;
            cyc++;
            @(negedge clk_p);
        end
        check("bp_finished", 64'(exp_i), 64'(GN));
        rs_if.row_ready = 1'b1;
        check_done_pulse("bp");

        // Back-to-back: frame B offered during frame A's last-row transfer
        offer(8'h00);
        for (int i = 0; i < GN; i++) begin
            @(negedge clk_p);
            gelu_valid_n = 1'b1;
            check_row("b2b_a", 8'h00, i);
        end
        check("b2b_accept_last", 64'(accept_n), 64'(0));
        offer(8'h20);
        @(negedge clk_p);
        gelu_valid_n = 1'b1;
        check_row("b2b_b0", 8'h20, 0);
        check("b2b_done_lo", 64'(frame_done_n), 64'(0));
        for (int i = 1; i < GN; i++) begin
            @(negedge clk_p);
            check_row("b2b_b", 8'h20, i);
            check("b2b_done_hi", 64'(frame_done_n), 64'(1));
        end
        @(negedge clk_p);
        check_done_pulse("b2b");

        // Drop: frame C offered while row 1 of frame A is on the bus
        offer(8'h00);
        @(negedge clk_p);
        gelu_valid_n = 1'b1;
        check_row("drop_a0", 8'h00, 0);
        @(negedge clk_p);
        check_row("drop_a1", 8'h00, 1);
        check("drop_accept", 64'(accept_n), 64'(1));
        offer(8'h60);
        for (int i = 2; i < GN; i++) begin
            @(negedge clk_p);
            gelu_valid_n = 1'b1;
            check_row("drop_a", 8'h00, i);
        end
        @(negedge clk_p);
        check_done_pulse("drop");
`ifdef GELU_STREAM_DROP_CNT_EN
        check("drop_cnt", 64'(drop_cnt), 64'(1));
`endif

        // Reset mid-frame while row 2 is held by backpressure
        offer(8'h30);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_p);
            gelu_valid_n = 1'b1;
            if (i == 2) rs_if.row_ready = 1'b0;
        end
        @(negedge clk_p);
        check_row("mid_hold", 8'h30, 2);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(rs_if.row_valid_n), 64'(1));
        check("mid_rst_idx", 64'(rs_if.row_idx), 64'(0));
        check("mid_rst_data", 64'(rs_if.row_data), 64'(0));
        check("mid_rst_accept", 64'(accept_n), 64'(0));
        check("mid_rst_done", 64'(frame_done_n), 64'(1));
        @(negedge clk_p);
        rst_n = 1'b1;
        rs_if.row_ready = 1'b1;
        @(negedge clk_p);
        check("post_rst_done", 64'(frame_done_n), 64'(1));
        check("post_rst_valid", 64'(rs_if.row_valid_n), 64'(1));
        offer(8'h40);
        for (int i = 0; i < GN; i++) begin
            @(negedge clk_p);
            gelu_valid_n = 1'b1;
            check_row("post_rst", 8'h40, i);
        end
        @(negedge clk_p);
        check_done_pulse("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
